// File: rtl/mult_table_reader.sv
// rtl/mult_table_reader.sv - single-outstanding requester for the mempy multiply lookup ROM
// Optional build macro: MULT_TABLE_READER_CHECK_EN (behavioural a*b cross-check driving err)
module mult_table_reader #(
    parameter int OPW    = 4,
    parameter int N      = 2 * OPW,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_a,
    input  logic [OPW-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_product,
    output logic [N-1:0]   mem_address,
    output logic           mem_read_en,
    output logic           mem_ce,
    input  logic [N-1:0]   mem_data,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t         state;
    state_t         state_nxt;
    logic [OPW-1:0] a_q;
    logic [OPW-1:0] b_q;
    logic [3:0]     cnt_q;
    logic [N-1:0]   product_q;
    logic           accept;
    logic           capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_ce    = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                mem_ce = 1'b1;
                if (cnt_q == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and address are decoded from the registered state so they move on the same edge.
    assign mem_read_en = mem_ce;
    assign mem_address = mem_ce ? {a_q, b_q} : '0;
    assign out_product = product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                cnt_q <= LAT_M1;
            end else if (state == READ && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                product_q <= mem_data;
            end
        end
    end

`ifdef MULT_TABLE_READER_CHECK_EN
    logic [N-1:0] expect_product;
    logic         err_q;

    assign expect_product = N'(a_q) * N'(b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (capture && mem_data != expect_product) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_table_reader.sv
// tb/tb_mult_table_reader.sv - directed self-checking bench for mult_table_reader
module tb_mult_table_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       corrupt;

    logic       in_valid, in_ready, out_valid, out_ready, mem_read_en, mem_ce, err;
    logic [3:0] in_a, in_b;
    logic [7:0] out_product, mem_address, mem_data;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, mem_read_en1, mem_ce1, err1;
    logic [3:0] in_a1, in_b1;
    logic [7:0] out_product1, mem_address1, mem_data1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] addr, input logic bad);
        logic [7:0] p;
        p = {4'b0, addr[7:4]} * {4'b0, addr[3:0]};
        if (bad && addr == 8'h22) p = 8'h00;
        return p;
    endfunction

    assign mem_data  = mem_ce  ? rom(mem_address, corrupt)  : 8'h00;
    assign mem_data1 = mem_ce1 ? rom(mem_address1, 1'b0)    : 8'h00;

    mult_table_reader #(.OPW(4), .N(8), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_ce(mem_ce),
        .mem_data(mem_data), .err(err)
    );

    mult_table_reader #(.OPW(4), .N(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_product(out_product1),
        .mem_address(mem_address1), .mem_read_en(mem_read_en1), .mem_ce(mem_ce1),
        .mem_data(mem_data1), .err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One RD_LAT=2 request with out_ready high; returns at the IDLE cycle after the handshake.
    task automatic run_pair(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        chk("pair_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        chk("pair_addr", mem_address, {a, b});
        tick();
        chk("pair_ce_hold", mem_ce, 1'b1);
        tick();
        chk("pair_valid", out_valid, 1'b1);
        chk("pair_product", out_product, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1; corrupt = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
        tick();
        tick();

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ce", mem_ce, 1'b0);
        chk("rst_read_en", mem_read_en, 1'b0);
        chk("rst_addr", mem_address, 8'h00);
        chk("rst_product", out_product, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_in_ready1", in_ready1, 1'b1);
        rst = 1'b0;
        tick();

        // RD_LAT=1 single read, a=3 b=5
        in_valid1 = 1'b1; in_a1 = 4'd3; in_b1 = 4'd5;
        tick();
        in_valid1 = 1'b0;
        chk("single_addr", mem_address1, 8'h35);
        chk("single_ce", mem_ce1, 1'b1);
        chk("single_read_en", mem_read_en1, 1'b1);
        chk("single_in_ready", in_ready1, 1'b0);
        chk("single_no_valid", out_valid1, 1'b0);
        tick();
        chk("single_valid", out_valid1, 1'b1);
        chk("single_product", out_product1, 8'h0F);
        chk("single_addr_drop", mem_address1, 8'h00);
        chk("single_ce_drop", mem_ce1, 1'b0);
        tick();
        chk("single_valid_drop", out_valid1, 1'b0);
        chk("single_idle", in_ready1, 1'b1);
        chk("single_hold", out_product1, 8'h0F);

        // RD_LAT=2 sweep of all pairs, one result every 4 cycles
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_pair(4'(a), 4'(b), 8'(a * b));
            end
        end
        chk("sweep_err", err, 1'b0);
        chk("sweep_last_product", out_product, 8'hE1);

        // Back-pressure: 7*9 stalled for 5 cycles with a second request waiting
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_product", out_product, 8'h3F);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_ce", mem_ce, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_release_valid", out_valid, 1'b1);
        tick();
        chk("bp_idle_in_ready", in_ready, 1'b1);
        chk("bp_idle_valid", out_valid, 1'b0);
        chk("bp_idle_hold", out_product, 8'h3F);
        tick();
        in_valid = 1'b0;
        chk("bp_second_addr", mem_address, 8'h12);
        chk("bp_second_busy", in_ready, 1'b0);
        tick();
        tick();
        chk("bp_second_product", out_product, 8'h02);
        tick();

        // Reset in the middle of READ
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6;
        tick();
        in_valid = 1'b0;
        chk("mid_ce", mem_ce, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ce_drop", mem_ce, 1'b0);
        chk("mid_addr_drop", mem_address, 8'h00);
        chk("mid_in_ready", in_ready, 1'b1);
        chk("mid_no_valid", out_valid, 1'b0);
        tick();
        chk("mid_still_no_valid", out_valid, 1'b0);
        chk("mid_still_idle", in_ready, 1'b1);
        tick();

        // Corrupted ROM entry for 2*2
        corrupt = 1'b1;
        in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("chk_valid", out_valid, 1'b1);
        chk("chk_product", out_product, 8'h00);
`ifdef MULT_TABLE_READER_CHECK_EN
        chk("chk_err_rise", err, 1'b1);
        tick();
        run_pair(4'd3, 4'd3, 8'h09);
        chk("chk_err_sticky", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("chk_err_clear", err, 1'b0);
`else
        chk("chk_err_tied", err, 1'b0);
        tick();
        run_pair(4'd3, 4'd3, 8'h09);
        chk("chk_err_tied_after", err, 1'b0);
`endif
        corrupt = 1'b0;
        chk("err1_quiet", err1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
